// File: rtl/envelope_extract.sv
// envelope_extract
//   Finds local minima (MODE=0) or maxima (MODE=1) on a signed sample stream,
//   computes the fixed-point slope between consecutive extrema with a serial
//   restoring divider, and emits one linearly interpolated envelope sample per
//   input time index between them.
//
// Ports
//   CLK        clock, rising edge
//   RST        synchronous active-high reset
//   in_valid   qualifies in_data, one sample per asserted cycle
//   in_data    signed input sample (DW)
//   out_ready  downstream accepts env_data when high with env_valid
//   env_valid  env_data holds a valid envelope sample
//   env_data   signed envelope sample (DW)
//   ext_valid  one-cycle pulse on an accepted extremum
//   ext_data   value of the accepted extremum (DW)
//   ext_time   time index of the accepted extremum (TW)
//   busy       divider running, a queue non-empty, or a segment being output
//   seg_ovf    sticky: an extremum was dropped because its queue was full
module envelope_extract #(
  parameter int DW    = 16,
  parameter int TW    = 16,
  parameter int FRAC  = 8,
  parameter int MODE  = 0,
  parameter int DEPTH = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  input  logic          out_ready,
  output logic          env_valid,
  output logic [DW-1:0] env_data,
  output logic          ext_valid,
  output logic [DW-1:0] ext_data,
  output logic [TW-1:0] ext_time,
  output logic          busy,
  output logic          seg_ovf
);

  localparam int NW  = DW + FRAC + 1;      // dividend / slope width
  localparam int AW  = NW + TW;            // accumulator width
  localparam int QAW = $clog2(DEPTH);
  localparam int CW  = $clog2(NW + 1);
  localparam logic [QAW:0]          DEPTH_C = (QAW + 1)'(DEPTH);
  localparam logic signed [AW-1:0]  ROUND_C = AW'(2 ** (FRAC - 1));
  localparam logic signed [AW-1:0]  ENV_MAX = AW'(2 ** (DW - 1) - 1);
  localparam logic signed [AW-1:0]  ENV_MIN = -ENV_MAX - AW'(1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DIV, S_PUSH} state_t;

  // ---------------- sample window ----------------
  logic [DW-1:0] win_a, win_b, win_c;
  logic [TW-1:0] t_cnt, t_a, t_b;
  logic [1:0]    fill;
  logic          win_upd;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      win_a <= '0; win_b <= '0; win_c <= '0;
      t_cnt <= '0; t_a <= '0; t_b <= '0;
      fill <= '0; win_upd <= 1'b0;
    end else begin
      win_upd <= in_valid && (fill == 2'd2);
      if (in_valid) begin
        win_c <= win_b;
        win_b <= win_a;
        win_a <= in_data;
        t_b   <= t_a;
        t_a   <= t_cnt;
        t_cnt <= t_cnt + 1'b1;
        if (fill != 2'd2) fill <= fill + 1'b1;
      end
    end
  end

  // Older neighbour compared strictly so a plateau reports its first sample.
  logic is_ext;
  always_comb begin
    if (MODE != 0)
      is_ext = win_upd && ($signed(win_b) > $signed(win_c)) && ($signed(win_b) >= $signed(win_a));
    else
      is_ext = win_upd && ($signed(win_b) < $signed(win_c)) && ($signed(win_b) <= $signed(win_a));
  end

  // ---------------- extremum queue ----------------
  logic [DW-1:0]  q_val  [DEPTH];
  logic [TW-1:0]  q_time [DEPTH];
  logic [QAW-1:0] q_wr, q_rd;
  logic [QAW:0]   q_cnt;
  logic           q_full, q_empty, q_push, q_pop;

  assign q_full  = (q_cnt == DEPTH_C);
  assign q_empty = (q_cnt == '0);
  // A full queue still takes the new entry if the head leaves this cycle.
  assign q_push  = is_ext && (!q_full || q_pop);

  assign ext_valid = q_push;
  assign ext_data  = win_b;
  assign ext_time  = t_b;

  // NOTE: storage arrays are not reset; occupancy counters alone decide validity.
  always_ff @(posedge CLK) begin
    if (q_push) begin
      q_val[q_wr]  <= win_b;
      q_time[q_wr] <= t_b;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      q_wr <= '0; q_rd <= '0; q_cnt <= '0; seg_ovf <= 1'b0;
    end else begin
      if (q_push) q_wr <= q_wr + 1'b1;
      if (q_pop)  q_rd <= q_rd + 1'b1;
      case ({q_push, q_pop})
        2'b10:   q_cnt <= q_cnt + 1'b1;
        2'b01:   q_cnt <= q_cnt - 1'b1;
        default: q_cnt <= q_cnt;
      endcase
      if (is_ext && !q_push) seg_ovf <= 1'b1;
    end
  end

  // ---------------- divider FSM ----------------
  state_t          state, state_nxt;
  logic            have_prev, seed;
  logic [DW-1:0]   prev_val, next_val;
  logic [TW-1:0]   prev_time, next_time, seg_len, rem;
  logic [NW-1:0]   dq;
  logic            neg;
  logic [CW-1:0]   div_cnt;
  logic            sf_full, sf_empty, sf_push, sf_pop;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    q_pop     = 1'b0;
    seed      = 1'b0;
    case (state)
      S_IDLE: begin
        if (!have_prev) begin
          if (!q_empty) begin
            q_pop = 1'b1;
            seed  = 1'b1;
          end
        end else if (!q_empty && !sf_full) begin
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        q_pop     = 1'b1;
        state_nxt = S_DIV;
      end
      S_DIV:   if (div_cnt == CW'(NW - 1)) state_nxt = S_PUSH;
      S_PUSH:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  logic [DW:0]   load_diff;
  logic [NW-1:0] load_dividend, slope_res;
  logic [TW:0]   div_rem_sh;
  logic [TW-1:0] div_rem_sub;
  logic          div_ge;

  assign load_diff     = {q_val[q_rd][DW-1], q_val[q_rd]} - {prev_val[DW-1], prev_val};
  assign load_dividend = {load_diff, {FRAC{1'b0}}};
  assign div_rem_sh    = {rem, dq[NW-1]};
  assign div_ge        = (div_rem_sh >= {1'b0, seg_len});
  // Remainder stays below seg_len, so the low TW bits of the difference are exact.
  assign div_rem_sub   = div_rem_sh[TW-1:0] - seg_len;
  assign slope_res     = neg ? -dq : dq;
  assign sf_push       = (state == S_PUSH);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE; have_prev <= 1'b0;
      prev_val <= '0; prev_time <= '0; next_val <= '0; next_time <= '0;
      seg_len <= '0; rem <= '0; dq <= '0; neg <= 1'b0; div_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (seed) begin
        prev_val  <= q_val[q_rd];
        prev_time <= q_time[q_rd];
        have_prev <= 1'b1;
      end
      case (state)
        S_LOAD: begin
          next_val  <= q_val[q_rd];
          next_time <= q_time[q_rd];
          seg_len   <= q_time[q_rd] - prev_time;
          neg       <= load_diff[DW];
          dq        <= load_diff[DW] ? -load_dividend : load_dividend;
          rem       <= '0;
          div_cnt   <= '0;
        end
        S_DIV: begin
          // dq shifts dividend bits out the top and quotient bits in the bottom.
          rem     <= div_ge ? div_rem_sub : div_rem_sh[TW-1:0];
          dq      <= {dq[NW-2:0], div_ge};
          div_cnt <= div_cnt + 1'b1;
        end
        S_PUSH: begin
          prev_val  <= next_val;
          prev_time <= next_time;
        end
        default: ;
      endcase
    end
  end

  // ---------------- segment FIFO ----------------
  logic [DW-1:0]  sf_pp    [DEPTH];
  logic [NW-1:0]  sf_slope [DEPTH];
  logic [TW-1:0]  sf_len   [DEPTH];
  logic [QAW-1:0] sf_wr, sf_rd;
  logic [QAW:0]   sf_cnt;

  assign sf_full  = (sf_cnt == DEPTH_C);
  assign sf_empty = (sf_cnt == '0);

  always_ff @(posedge CLK) begin
    if (sf_push) begin
      sf_pp[sf_wr]    <= prev_val;
      sf_slope[sf_wr] <= slope_res;
      sf_len[sf_wr]   <= seg_len;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sf_wr <= '0; sf_rd <= '0; sf_cnt <= '0;
    end else begin
      if (sf_push) sf_wr <= sf_wr + 1'b1;
      if (sf_pop)  sf_rd <= sf_rd + 1'b1;
      case ({sf_push, sf_pop})
        2'b10:   sf_cnt <= sf_cnt + 1'b1;
        2'b01:   sf_cnt <= sf_cnt - 1'b1;
        default: sf_cnt <= sf_cnt;
      endcase
    end
  end

  // ---------------- output generator ----------------
  logic                 out_active, accept, last_acc;
  logic signed [AW-1:0] acc, acc_round, env_rnd;
  logic [NW-1:0]        cur_slope;
  logic [TW-1:0]        samp_left;

  assign accept   = out_active && out_ready;
  assign last_acc = accept && (samp_left == TW'(1));
  // Loading on the last accept of the current segment avoids a bubble.
  assign sf_pop   = !sf_empty && (!out_active || last_acc);

  always_ff @(posedge CLK) begin
    if (RST) begin
      out_active <= 1'b0; acc <= '0; cur_slope <= '0; samp_left <= '0;
    end else if (sf_pop) begin
      out_active <= 1'b1;
      acc        <= {{(AW-DW){sf_pp[sf_rd][DW-1]}}, sf_pp[sf_rd]} <<< FRAC;
      cur_slope  <= sf_slope[sf_rd];
      samp_left  <= sf_len[sf_rd];
    end else if (accept) begin
      acc       <= acc + {{(AW-NW){cur_slope[NW-1]}}, cur_slope};
      samp_left <= samp_left - 1'b1;
      if (last_acc) out_active <= 1'b0;
    end
  end

  assign acc_round = acc + ROUND_C;
  assign env_rnd   = acc_round >>> FRAC;

  always_comb begin
    env_data = env_rnd[DW-1:0];
    if (env_rnd > ENV_MAX)      env_data = ENV_MAX[DW-1:0];
    else if (env_rnd < ENV_MIN) env_data = ENV_MIN[DW-1:0];
  end

  assign env_valid = out_active;
  assign busy      = (state != S_IDLE) || !q_empty || !sf_empty || out_active;

endmodule

// File: tb/tb_envelope_extract.sv
// Self-checking bench for envelope_extract.
// Three instances share stimulus: u_a (minima, DEPTH 4), u_b (maxima on the
// negated stream, DEPTH 4) and u_c (minima, DEPTH 2). Expected envelope
// samples come from a behavioural model of the extremum/interpolation rules
// and sit in per-instance queues that are popped on each accepted sample.
module tb_envelope_extract;

  localparam int DW = 16;
  localparam int TW = 16;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [DW-1:0] in_neg;
  logic          out_ready = 1'b0;

  logic          env_valid_a, ext_valid_a, busy_a, seg_ovf_a;
  logic [DW-1:0] env_data_a, ext_data_a;
  logic [TW-1:0] ext_time_a;
  logic          env_valid_b, ext_valid_b, busy_b, seg_ovf_b;
  logic [DW-1:0] env_data_b, ext_data_b;
  logic [TW-1:0] ext_time_b;
  logic          env_valid_c, ext_valid_c, busy_c, seg_ovf_c;
  logic [DW-1:0] env_data_c, ext_data_c;
  logic [TW-1:0] ext_time_c;

  assign in_neg = -in_data;

  always #5 CLK = ~CLK;

  envelope_extract #(.DW(DW), .TW(TW), .FRAC(8), .MODE(0), .DEPTH(4)) u_a (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_data(in_data), .out_ready(out_ready),
    .env_valid(env_valid_a), .env_data(env_data_a), .ext_valid(ext_valid_a),
    .ext_data(ext_data_a), .ext_time(ext_time_a), .busy(busy_a), .seg_ovf(seg_ovf_a));

  envelope_extract #(.DW(DW), .TW(TW), .FRAC(8), .MODE(1), .DEPTH(4)) u_b (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_data(in_neg), .out_ready(out_ready),
    .env_valid(env_valid_b), .env_data(env_data_b), .ext_valid(ext_valid_b),
    .ext_data(ext_data_b), .ext_time(ext_time_b), .busy(busy_b), .seg_ovf(seg_ovf_b));

  envelope_extract #(.DW(DW), .TW(TW), .FRAC(8), .MODE(0), .DEPTH(2)) u_c (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_data(in_data), .out_ready(out_ready),
    .env_valid(env_valid_c), .env_data(env_data_c), .ext_valid(ext_valid_c),
    .ext_data(ext_data_c), .ext_time(ext_time_c), .busy(busy_c), .seg_ovf(seg_ovf_c));

  int n_cmp = 0;
  int n_err = 0;
  int exp_a[$], exp_b[$], exp_c[$];
  int exp_xv[$], exp_xt[$];
  int stim[$];
  int drv_step[$];
  int m_ev[$], m_xv[$], m_xt[$];
  bit en_a, en_b, en_c, en_ext;
  int step_no = 0;
  int acc_cnt_a = 0;

  // One clock: drive inputs on the falling edge, then score what the DUTs
  // present (outputs only change on the rising edge).
  task automatic step(input logic v, input int d, input logic r);
    int e;
    @(negedge CLK);
    step_no++;
    in_valid  = v;
    in_data   = d[DW-1:0];
    out_ready = r;
    if (en_a && env_valid_a && out_ready) begin
      acc_cnt_a++;
      n_cmp++;
      if (exp_a.size() == 0) begin
        n_err++;
        $display("FAIL env_a_extra: got %0d, expected no sample", $signed(env_data_a));
      end else begin
        e = exp_a.pop_front();
        if ($signed(env_data_a) !== e) begin
          n_err++;
          $display("FAIL env_a: got %0d, expected %0d", $signed(env_data_a), e);
        end
      end
    end
    if (en_b && env_valid_b && out_ready) begin
      n_cmp++;
      if (exp_b.size() == 0) begin
        n_err++;
        $display("FAIL env_b_extra: got %0d, expected no sample", $signed(env_data_b));
      end else begin
        e = exp_b.pop_front();
        if ($signed(env_data_b) !== e) begin
          n_err++;
          $display("FAIL env_b: got %0d, expected %0d", $signed(env_data_b), e);
        end
      end
    end
    if (en_c && env_valid_c && out_ready) begin
      n_cmp++;
      if (exp_c.size() == 0) begin
        n_err++;
        $display("FAIL env_c_extra: got %0d, expected no sample", $signed(env_data_c));
      end else begin
        e = exp_c.pop_front();
        if ($signed(env_data_c) !== e) begin
          n_err++;
          $display("FAIL env_c: got %0d, expected %0d", $signed(env_data_c), e);
        end
      end
    end
    if (en_ext && ext_valid_a) begin
      n_cmp++;
      if (exp_xv.size() == 0) begin
        n_err++;
        $display("FAIL ext_a_extra: got %0d@%0d, expected none", $signed(ext_data_a), ext_time_a);
      end else begin
        int xv, xt, xs;
        xv = exp_xv.pop_front();
        xt = exp_xt.pop_front();
        xs = drv_step[xt + 1] + 1;
        if ($signed(ext_data_a) !== xv || ext_time_a !== TW'(xt) || step_no !== xs) begin
          n_err++;
          $display("FAIL ext_a: got %0d@t%0d step %0d, expected %0d@t%0d step %0d",
                   $signed(ext_data_a), ext_time_a, step_no, xv, xt, xs);
        end
      end
    end
  endtask

  // Behavioural reference: extremum rule, truncating division, round half up.
  task automatic model(input bit upper, input bit negate);
    longint num, slope, acc, r;
    int len;
    m_ev.delete(); m_xv.delete(); m_xt.delete();
    for (int i = 2; i < stim.size(); i++) begin
      int a, b, c;
      c = negate ? -stim[i-2] : stim[i-2];
      b = negate ? -stim[i-1] : stim[i-1];
      a = negate ? -stim[i]   : stim[i];
      if (upper ? (b > c && b >= a) : (b < c && b <= a)) begin
        m_xv.push_back(b);
        m_xt.push_back(i - 1);
      end
    end
    for (int k = 1; k < m_xv.size(); k++) begin
      len   = m_xt[k] - m_xt[k-1];
      num   = longint'(m_xv[k] - m_xv[k-1]) * 256;
      slope = num / len;
      for (int j = 0; j < len; j++) begin
        acc = longint'(m_xv[k-1]) * 256 + j * slope;
        r   = (acc + 128) >>> 8;
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
        m_ev.push_back(int'(r));
      end
    end
  endtask

  task automatic drive(input logic r);
    foreach (stim[i]) begin
      step(1'b1, stim[i], r);
      drv_step.push_back(step_no);
    end
  endtask

  function automatic bit pending();
    return (en_a && exp_a.size() != 0) || (en_b && exp_b.size() != 0) ||
           (en_c && exp_c.size() != 0) || (en_ext && exp_xv.size() != 0);
  endfunction

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (pending() && n < budget) begin
      step(1'b0, 0, 1'b1);
      n++;
    end
    if (pending()) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: left a=%0d b=%0d c=%0d ext=%0d, expected 0",
               exp_a.size(), exp_b.size(), exp_c.size(), exp_xv.size());
      exp_a.delete(); exp_b.delete(); exp_c.delete(); exp_xv.delete(); exp_xt.delete();
    end
    repeat (40) step(1'b0, 0, 1'b1);
  endtask

  task automatic do_reset();
    en_a = 0; en_b = 0; en_c = 0; en_ext = 0;
    exp_a.delete(); exp_b.delete(); exp_c.delete(); exp_xv.delete(); exp_xt.delete();
    drv_step.delete();
    @(negedge CLK);
    RST = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({env_valid_a, env_data_a, ext_valid_a, ext_data_a, ext_time_a, busy_a, seg_ovf_a} !== '0) begin
      n_err++; $display("FAIL reset_a: got outputs nonzero, expected all 0");
    end
    n_cmp++;
    if ({env_valid_b, env_data_b, ext_valid_b, ext_data_b, ext_time_b, busy_b, seg_ovf_b} !== '0) begin
      n_err++; $display("FAIL reset_b: got outputs nonzero, expected all 0");
    end
    n_cmp++;
    if ({env_valid_c, env_data_c, ext_valid_c, ext_data_c, ext_time_c, busy_c, seg_ovf_c} !== '0) begin
      n_err++; $display("FAIL reset_c: got outputs nonzero, expected all 0");
    end
  endtask

  // Minima 0@t1, 8@t4, 4@t7: envelope 0,3,5 then 8,7,5.
  task automatic test_minima();
    do_reset();
    stim = '{10, 0, 10, 10, 8, 10, 12, 4, 12};
    model(1'b0, 1'b0);
    exp_a = m_ev; exp_xv = m_xv; exp_xt = m_xt;
    en_a = 1; en_ext = 1;
    drive(1'b1);
    drain(500);
    n_cmp++;
    if (busy_a !== 1'b0) begin
      n_err++; $display("FAIL minima_idle_busy: got %b, expected 0", busy_a);
    end
  endtask

  // Same stream negated into the maxima instance: 0,-3,-5 then -8,-7,-5.
  task automatic test_upper();
    do_reset();
    stim = '{10, 0, 10, 10, 8, 10, 12, 4, 12};
    model(1'b1, 1'b1);
    exp_b = m_ev;
    en_b = 1;
    drive(1'b1);
    drain(500);
  endtask

  // -100@t2 to -110@t7: L=5, slope -512, envelope -100..-108 step -2.
  task automatic test_neg_slope();
    do_reset();
    stim = '{0, -50, -100, -50, -20, -60, -80, -110, -90};
    model(1'b0, 1'b0);
    exp_a = m_ev;
    en_a = 1;
    drive(1'b1);
    drain(500);
  endtask

  task automatic test_backpressure();
    int n;
    do_reset();
    stim = '{0, -50, -100, -50, -20, -60, -80, -110, -90};
    model(1'b0, 1'b0);
    exp_a = m_ev;
    en_a = 1;
    acc_cnt_a = 0;
    drive(1'b1);
    n = 0;
    while (acc_cnt_a < 2 && n < 500) begin
      step(1'b0, 0, 1'b1);
      n++;
    end
    n_cmp++;
    if (acc_cnt_a < 2) begin
      n_err++; $display("FAIL bp_start_timeout: got %0d samples, expected 2", acc_cnt_a);
    end
    repeat (20) begin
      step(1'b0, 0, 1'b0);
      n_cmp++;
      if (env_valid_a !== 1'b1 || exp_a.size() == 0 || $signed(env_data_a) !== exp_a[0]) begin
        n_err++;
        $display("FAIL bp_hold: got valid=%b data=%0d, expected valid=1 data=%0d",
                 env_valid_a, $signed(env_data_a), (exp_a.size() != 0) ? exp_a[0] : 0);
      end
    end
    drain(500);
  endtask

  // Minima lie on the line v(t) = -(t-1), so any merged segment interpolates
  // to the same values: output n must be -n whatever extrema were dropped.
  task automatic test_overflow();
    int n;
    do_reset();
    en_c = 1;
    for (int k = 0; k < 20; k++) exp_c.push_back(-k);
    stim.delete();
    stim.push_back(100);
    for (int k = 0; k < 10; k++) begin
      stim.push_back(-2 * k);
      stim.push_back(100);
    end
    drive(1'b0);
    n_cmp++;
    if (seg_ovf_c !== 1'b1) begin
      n_err++; $display("FAIL ovf_set: got %b, expected 1", seg_ovf_c);
    end
    n = 0;
    while (busy_c && n < 3000) begin
      step(1'b0, 0, 1'b1);
      n++;
    end
    n_cmp++;
    if (busy_c !== 1'b0 || seg_ovf_c !== 1'b1) begin
      n_err++; $display("FAIL ovf_sticky: got busy=%b ovf=%b, expected busy=0 ovf=1", busy_c, seg_ovf_c);
    end
    stim = '{-20, 100};
    drive(1'b1);
    drain(1000);
  endtask

  task automatic test_reset_mid();
    do_reset();
    stim.delete();
    stim.push_back(100);
    for (int k = 0; k < 10; k++) begin
      stim.push_back(-2 * k);
      stim.push_back(100);
    end
    drive(1'b0);
    repeat (30) step(1'b0, 0, 1'b0);
    n_cmp++;
    if (busy_a !== 1'b1 || seg_ovf_c !== 1'b1) begin
      n_err++; $display("FAIL rst_mid_pre: got busy_a=%b ovf_c=%b, expected 1 1", busy_a, seg_ovf_c);
    end
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    n_cmp++;
    if ({env_valid_a, busy_a, seg_ovf_a, env_valid_c, busy_c, seg_ovf_c} !== 6'b0) begin
      n_err++;
      $display("FAIL rst_mid_clear: got va=%b ba=%b oa=%b vc=%b bc=%b oc=%b, expected all 0",
               env_valid_a, busy_a, seg_ovf_a, env_valid_c, busy_c, seg_ovf_c);
    end
    RST = 1'b0;
    drv_step.delete();
    stim = '{0, -50, -100, -50, -20, -60, -80, -110, -90};
    model(1'b0, 1'b0);
    exp_a = m_ev;
    en_a = 1;
    drive(1'b1);
    drain(500);
  endtask

  initial begin
    test_reset();
    test_minima();
    test_upper();
    test_neg_slope();
    test_backpressure();
    test_overflow();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
